// File: rtl/cap_sensor_scanner_pkg.sv
// Shared definitions for the capacitive pad scanner: scan FSM encoding,
// default pad count and the memory-mapped register offsets seen by the CPU.
package cap_sensor_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISCHARGE = 2'd1,
    ST_CHARGE    = 2'd2,
    ST_EVAL      = 2'd3
  } scan_state_t;

  localparam int NUM_PADS = 9;

  localparam logic [7:0] ADDR_TOUCHED      = 8'h00;
  localparam logic [7:0] ADDR_TOUCH_EVENT  = 8'h04;
  localparam logic [7:0] ADDR_CLEAR_EVENTS = 8'h08;
  localparam logic [7:0] ADDR_COUNT_SEL    = 8'h0C;

endpackage

// File: rtl/cap_pad_channel.sv
// One pad: input synchronizer, charge-time capture, committed count,
// debounced touched bit and sticky touch event.
module cap_pad_channel #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 4000,
  parameter int DEBOUNCE = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pad_in,
  input  logic             clr_cap,
  input  logic             charging,
  input  logic             eval,
  input  logic             clr_event,
  input  logic [CNT_W-1:0] charge_cnt,
  input  logic [CNT_W-1:0] threshold,
  output logic             captured,
  output logic [CNT_W-1:0] count,
  output logic             touched,
  output logic             touch_event
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cap_cnt;
  logic [CNT_W-1:0] eval_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic             raw;
  logic             flip;

  // A pad that never rose during the charge phase counts as TIMEOUT.
  assign eval_cnt = captured ? cap_cnt : CNT_W'(TIMEOUT);
  assign raw      = (eval_cnt >= threshold);
  assign flip     = (raw != touched) && (db_cnt == DB_W'(DEBOUNCE - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync        <= '0;
      captured    <= 1'b0;
      cap_cnt     <= '0;
      count       <= '0;
      db_cnt      <= '0;
      touched     <= 1'b0;
      touch_event <= 1'b0;
    end else begin
      sync <= {sync[0], pad_in};
      if (clr_cap) begin
        captured <= 1'b0;
      end else if (charging && sync[1] && !captured) begin
        captured <= 1'b1;
        cap_cnt  <= charge_cnt;
      end
      if (eval) begin
        count <= eval_cnt;
        if (raw == touched || flip) db_cnt <= '0;
        else                        db_cnt <= db_cnt + 1'b1;
        if (flip) touched <= ~touched;
      end
      // Set has priority over a same-cycle clear so no touch is lost.
      touch_event <= (touch_event & ~clr_event) | (eval && flip && !touched);
    end
  end

endmodule

// File: rtl/cap_sensor_scanner.sv
// Capacitive pad scanner: discharge/charge/evaluate loop driving the shared
// charge line and timing every pad into a debounced touched mask.
module cap_sensor_scanner #(
  parameter int NUM_PADS         = cap_sensor_scanner_pkg::NUM_PADS,
  parameter int CNT_W            = 16,
  parameter int DISCHARGE_CYCLES = 500,
  parameter int TIMEOUT          = 4000,
  parameter int DEBOUNCE         = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [CNT_W-1:0]    threshold,
  input  logic [NUM_PADS-1:0] capacitive_sensors_in,
  output logic                capacitive_sensors_out,
  input  logic [NUM_PADS-1:0] clear_events,
  input  logic [3:0]          count_sel,
  output logic [CNT_W-1:0]    count_out,
  output logic [NUM_PADS-1:0] touched,
  output logic [NUM_PADS-1:0] touch_event,
  output logic                scan_done
);
  import cap_sensor_scanner_pkg::*;

  localparam int DIS_W = $clog2(DISCHARGE_CYCLES + 1);

  scan_state_t                    state;
  logic [DIS_W-1:0]               dis_cnt;
  logic [CNT_W-1:0]               charge_cnt;
  logic [NUM_PADS-1:0]            captured;
  logic [NUM_PADS-1:0][CNT_W-1:0] counts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                  <= ST_IDLE;
      dis_cnt                <= '0;
      charge_cnt             <= '0;
      capacitive_sensors_out <= 1'b0;
      scan_done              <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: if (enable) begin
          state   <= ST_DISCHARGE;
          dis_cnt <= '0;
        end
        ST_DISCHARGE: if (dis_cnt == DIS_W'(DISCHARGE_CYCLES - 1)) begin
          state                  <= ST_CHARGE;
          charge_cnt             <= '0;
          capacitive_sensors_out <= 1'b1;
        end else begin
          dis_cnt <= dis_cnt + 1'b1;
        end
        ST_CHARGE: if (&captured || charge_cnt == CNT_W'(TIMEOUT - 1)) begin
          state                  <= ST_EVAL;
          capacitive_sensors_out <= 1'b0;
          scan_done              <= 1'b1;
        end else begin
          charge_cnt <= charge_cnt + 1'b1;
        end
        ST_EVAL: begin
          state   <= enable ? ST_DISCHARGE : ST_IDLE;
          dis_cnt <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cap_pad_channel #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .DEBOUNCE(DEBOUNCE)
  ) u_pad [NUM_PADS-1:0] (
    .clock      (clock),
    .reset      (reset),
    .pad_in     (capacitive_sensors_in),
    .clr_cap    (state == ST_DISCHARGE),
    .charging   (state == ST_CHARGE),
    .eval       (state == ST_EVAL),
    .clr_event  (clear_events),
    .charge_cnt (charge_cnt),
    .threshold  (threshold),
    .captured   (captured),
    .count      (counts),
    .touched    (touched),
    .touch_event(touch_event)
  );

  always_comb begin
    count_out = '0;
    for (int i = 0; i < NUM_PADS; i++)
      if (count_sel == 4'(i)) count_out = counts[i];
  end

endmodule

// File: doc/cap_sensor_scanner.md
Name: cap_sensor_scanner

Overview:
- Measurement side of the whack-a-mole touch interface. Drives the shared capacitive charge line (`capacitive_sensors_out`) and times each of the 9 pad inputs (`capacitive_sensors_in`) as it charges.
- Turns charge times into a debounced per-pad "touched" mask, plus sticky touch events that the processor reads through the skeleton's memory-mapped I/O.
- Runs continuously: discharge, charge, evaluate, repeat, while enabled.

Parameters:
- NUM_PADS, 9, number of pad inputs.
- CNT_W, 16, width of the charge-time counter and of the threshold.
- DISCHARGE_CYCLES, 500, cycles the charge line is held low before each charge phase (minimum 1).
- TIMEOUT, 4000, maximum charge cycles; also the count recorded for a pad that never rises (must be < 2^CNT_W).
- DEBOUNCE, 3, consecutive agreeing scans needed to flip a pad's touched state (minimum 1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- enable  in  1  run scans while high.
- threshold  in  CNT_W  charge count at or above which a pad is raw-touched.
- capacitive_sensors_in  in  NUM_PADS  raw asynchronous pad levels.
- capacitive_sensors_out  out  1  charge drive (0 = discharge, 1 = charge).
- clear_events  in  NUM_PADS  write-1-to-clear for touch_event bits.
- count_sel  in  4  pad index for count_out.
- count_out  out  CNT_W  last captured count of pad count_sel; 0 if count_sel >= NUM_PADS.
- touched  out  NUM_PADS  debounced touch mask.
- touch_event  out  NUM_PADS  sticky, set on each touched 0->1 transition.
- scan_done  out  1  one-cycle pulse when a scan's results are committed.

Behaviour:
- Reset values (asserted asynchronously): capacitive_sensors_out=0, touched=0, touch_event=0, scan_done=0, all captured counts=0, debounce counters=0, FSM=IDLE, synchronizer flops=0.
- Reset mid-scan aborts immediately; no partial results are committed.
- Inputs pass through a 2-flop synchronizer; all capture logic uses the synchronized value.
- IDLE: capacitive_sensors_out=0. When enable=1, go to DISCHARGE next cycle.
- DISCHARGE: capacitive_sensors_out=0 for exactly DISCHARGE_CYCLES cycles, then go to CHARGE. Clear all per-pad captured flags.
- CHARGE: capacitive_sensors_out=1. The charge counter is 0 in the first CHARGE cycle and increments by 1 each cycle.
  - A pad whose synchronized input is 1 and is not yet captured stores the counter value.
  - Because of the synchronizer, a pad that rises k cycles after CHARGE entry records k+2.
  - Exit to EVAL on the cycle after all pads are captured, or when the counter reaches TIMEOUT-1.
  - Uncaptured pads record TIMEOUT.
- EVAL (one cycle):
  - raw[i] = (count[i] >= threshold). threshold is sampled in this cycle only.
  - Per-pad debounce:
    - raw==touched: clear the debounce counter.
    - raw!=touched: increment the counter. When it reaches DEBOUNCE, toggle touched and clear the counter.
  - Drive scan_done=1 for this cycle. touched and count_out update on the same clock edge that ends EVAL.
  - Next state: DISCHARGE if enable=1, else IDLE.
- enable dropping mid-scan: the current scan completes normally, then the FSM goes to IDLE.
- touch_event[i]:
  - Set on the edge where touched[i] goes 0->1.
  - Cleared by clear_events[i]=1.
  - A simultaneous set and clear leaves the bit set.
- count_out is combinational from the stored counts and count_sel.

Decomposition:
- Shared package: FSM state encoding (IDLE, DISCHARGE, CHARGE, EVAL), NUM_PADS, the I/O address offsets for touched / touch_event / clear_events / count_sel.
- One natural sub-module, `cap_pad_channel`, instantiated NUM_PADS times. Each instance holds the synchronizer, captured flag, stored count, debounce counter, touched bit and event bit.
- The top level holds the FSM, the discharge and charge counters, and the count_out mux.

Test Plan (unless stated: DISCHARGE_CYCLES=4, TIMEOUT=64, DEBOUNCE=1, threshold=20, enable=1):
- Reset: assert reset mid-CHARGE -> capacitive_sensors_out=0 in the same cycle; touched=0, touch_event=0, scan_done=0; after release, first DISCHARGE lasts exactly 4 cycles.
- All pads rise 5 cycles after CHARGE entry -> all counts=7, touched=0x000, one scan_done pulse; count_sel=2 gives count_out=7.
- Pad 3 rises at 30, others at 5 -> count[3]=32, touched=0x008, touch_event=0x008. clear_events=0x008 together with a fresh 0->1 on pad 3 -> bit stays 1.
- Pad 8 never rises -> count[8]=64, touched[8]=1, CHARGE lasts exactly 64 cycles.
- DEBOUNCE=3, pad 0 slow (count 40) on scans 1-2 and fast on scan 3 -> touched[0] stays 0. Slow on 3 consecutive scans -> touched[0]=1 at the third scan_done.
- Drop enable during CHARGE -> that scan completes with scan_done, then IDLE with capacitive_sensors_out=0 and no further scan_done.
